mult_addshift_n: RTL and testbench

- Parametrised signed add-shift multiplier with controller and datapath in one block; successor to the fixed 8-bit Clear/Load/Run multiplier.
- Computes S × B, both WIDTH-bit two's complement, into the 2·WIDTH-bit pair {A,B} plus sign/carry bit X.
- Uses a counter-driven FSM in place of unrolled per-bit states, with a Run/Done handshake.
- Sits between debounced switch/button inputs and the hex-display drivers in the lab top level.

---
 rtl/mult_addshift_n.sv | 120 ++++++++++++
 tb/tb_mult_addshift_n.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mult_addshift_n.sv
// Signed add-shift multiplier: S x B into {X,A,B} with a Run/Done handshake.
// Optional overflow flag enabled by defining MULT_OVF_EN.
module mult_addshift_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load_B,
    input  logic             Run,
    input  logic [WIDTH-1:0] Sw,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy,
    output logic             Done,
    output logic             Ovf
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] s_q;
    logic [CW-1:0]   cnt;
    logic            run_q;
    logic [WIDTH:0]  sum_c;

    // Final partial product carries negative weight in two's complement.
    always_comb begin
        if (cnt == LAST)
            sum_c = {Aval[WIDTH-1], Aval} - {s_q[WIDTH-1], s_q};
        else
            sum_c = {Aval[WIDTH-1], Aval} + {s_q[WIDTH-1], s_q};
    end

`ifdef MULT_OVF_EN
    // Evaluated on the post-shift values, i.e. the final product.
    logic ovf_c;
    assign ovf_c = ({X, Aval[WIDTH-1:1]} != {WIDTH{Aval[0]}}) || (X != Aval[0]);
`else
    assign Ovf = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            Aval  <= '0;
            Bval  <= '0;
            X     <= 1'b0;
            s_q   <= '0;
            cnt   <= '0;
            run_q <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
`ifdef MULT_OVF_EN
            Ovf   <= 1'b0;
`endif
        end else begin
            run_q <= Run;
            case (state)
                IDLE: begin
                    if (Load_B) begin
                        Bval <= Sw;
                        Aval <= '0;
                        X    <= 1'b0;
                    end else if (Run && !run_q) begin
                        s_q   <= Sw;
                        state <= CLR;
                        Busy  <= 1'b1;
                    end
                end
                CLR: begin
                    Aval  <= '0;
                    X     <= 1'b0;
                    cnt   <= '0;
                    state <= ADD;
                end
                ADD: begin
                    if (Bval[0]) begin
                        X    <= sum_c[WIDTH];
                        Aval <= sum_c[WIDTH-1:0];
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    Aval <= {X, Aval[WIDTH-1:1]};
                    Bval <= {Aval[0], Bval[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
`ifdef MULT_OVF_EN
                        Ovf   <= ovf_c;
`endif
                    end else begin
                        cnt   <= cnt + CW'(1);
                        state <= ADD;
                    end
                end
                DONE: begin
                    if (!Run) begin
                        state <= IDLE;
                        Done  <= 1'b0;
`ifdef MULT_OVF_EN
                        Ovf   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_addshift_n.sv
// Randomised self-checking bench for mult_addshift_n against an integer product model.
module tb_mult_addshift_n;

    localparam int unsigned W = 8;

    logic         Clk;
    logic         Reset;
    logic         Load_B;
    logic         Run;
    logic [W-1:0] Sw;
    logic [W-1:0] Aval;
    logic [W-1:0] Bval;
    logic         X;
    logic         Busy;
    logic         Done;
    logic         Ovf;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] b_model;

    mult_addshift_n #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Load_B(Load_B), .Run(Run), .Sw(Sw),
        .Aval(Aval), .Bval(Bval), .X(X), .Busy(Busy), .Done(Done), .Ovf(Ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_b(input logic [W-1:0] v);
        Load_B = 1'b1;
        Sw     = v;
        tick();
        Load_B = 1'b0;
        check("load_b", Bval, v);
        check("load_a", Aval, '0);
        b_model = v;
    endtask

    // Start on a Run rise and wait for Done; optionally poke Load_B mid-operation.
    task automatic start_mult(input logic [W-1:0] s, input bit poke_load);
        logic signed [2*W-1:0] p;
        logic exp_ovf;
        int k;
        bit got_done;
        p = $signed({{W{s[W-1]}}, s}) * $signed({{W{b_model[W-1]}}, b_model});
        exp_ovf = 1'b0;
`ifdef MULT_OVF_EN
        exp_ovf = (p > 127) || (p < -128);
`endif
        Sw  = s;
        Run = 1'b1;
        tick();
        check("busy_start", Busy, 1'b1);
        k = 0;
        got_done = 1'b0;
        while (!got_done && k < 100) begin
            Sw = W'($urandom);
            if (poke_load && k == 2) begin
                Load_B = 1'b1;
                Sw     = 8'h55;
            end
            if (poke_load && k == 10) Load_B = 1'b0;
            tick();
            k++;
            if (Done) got_done = 1'b1;
        end
        check("latency", 64'(k), 64'(2 * W + 1));
        check("prod_hi", Aval, p[2*W-1:W]);
        check("prod_lo", Bval, p[W-1:0]);
        check("sign_x", X, p[2*W-1]);
        check("busy_done", Busy, 1'b0);
        check("ovf", Ovf, exp_ovf);
        b_model = p[W-1:0];
    endtask

    task automatic drop_run();
        Run = 1'b0;
        tick();
        check("done_fall", Done, 1'b0);
        check("busy_idle", Busy, 1'b0);
        check("ovf_idle", Ovf, 1'b0);
    endtask

    initial begin
        int hold_err;
        logic [W-1:0] a_snap;
        Reset  = 1'b1;
        Load_B = 1'b0;
        Run    = 1'b0;
        Sw     = '0;
        b_model = '0;
        tick();
        tick();
        Reset = 1'b0;
        check("rst_a", Aval, '0);
        check("rst_b", Bval, '0);
        check("rst_x", X, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_ovf", Ovf, 1'b0);

        // -3 x 7 and -128 x -128
        load_b(8'hFD); start_mult(8'h07, 1'b0); drop_run();
        load_b(8'h80); start_mult(8'h80, 1'b0); drop_run();

        // Chaining through retained B
        load_b(8'h03); start_mult(8'h02, 1'b0); drop_run();
        start_mult(8'h02, 1'b0); drop_run();

        // Run held high: single multiply, Done stays asserted
        load_b(8'h05); start_mult(8'hF3, 1'b0);
        hold_err = 0;
        a_snap = Aval;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (Done !== 1'b1 || Busy !== 1'b0 || Aval !== a_snap) hold_err++;
        end
        check("hold_run", 64'(hold_err), 64'd0);
        drop_run();

        // Reset mid-operation
        load_b(8'h11);
        Sw  = 8'h22;
        Run = 1'b1;
        tick();
        repeat (4) tick();
        Reset = 1'b1;
        Run   = 1'b0;
        tick();
        Reset = 1'b0;
        check("mrst_a", Aval, '0);
        check("mrst_b", Bval, '0);
        check("mrst_x", X, 1'b0);
        check("mrst_busy", Busy, 1'b0);
        check("mrst_done", Done, 1'b0);
        b_model = '0;
        tick();
        check("mrst_idle", Busy, 1'b0);
        load_b(8'h09); start_mult(8'hFA, 1'b0); drop_run();

        // Load_B during ADD/SHIFT is ignored
        load_b(8'h33); start_mult(8'hC5, 1'b1); drop_run();

        // Load_B and Run rise together: load wins, no start
        Load_B = 1'b1;
        Run    = 1'b1;
        Sw     = 8'h4C;
        tick();
        Load_B = 1'b0;
        check("both_busy", Busy, 1'b0);
        check("both_b", Bval, 8'h4C);
        b_model = 8'h4C;
        tick();
        check("both_nostart", Busy, 1'b0);
        Run = 1'b0;
        tick();
        start_mult(8'h03, 1'b0); drop_run();

        // Random operands
        for (int i = 0; i < 20; i++) begin
            load_b(W'($urandom));
            start_mult(W'($urandom), 1'b0);
            drop_run();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
